// File: rtl/video_vram_arbiter.sv
// video_vram_arbiter
//   Owns the single 14-bit VRAM port and time-shares it between the render
//   fetch engine and host PPUADDR/PPUDATA accesses. Holds the host VRAM
//   address (v), the PPUADDR write toggle, the PPUDATA read buffer and the
//   post-access auto-increment. Slots are paced by I_tick (dot-clock enable).
//
//   Slot timing: the IDLE tick that grants a slot counts as its first tick.
//   The slot state is then held until the P_access_ticks-th tick, where read
//   data is sampled and the state drops back to IDLE. The next tick is the
//   next grant, so a continuously requesting client gets one slot every
//   P_access_ticks ticks. With P_access_ticks=1 the slot completes on the
//   clock after the grant.
//
//   Optional build macro: VIDEO_VRAM_STARVE_GUARD_EN
//     defined   - a host op that has waited P_starve_ticks ticks is granted
//                 at the next IDLE decision even while render requests.
//     undefined - strict render priority.
//
//   Ports:
//     I_clock, I_reset (async, active low), I_tick (dot enable)
//     render : I_rend_req/I_rend_addr in, O_rend_ack/O_rend_data out
//     host   : I_host_addr_wr, I_host_data_wr, I_host_data_rd, I_host_data,
//              I_toggle_clr, I_incr32 in; O_host_rdbuf, O_host_busy,
//              O_overrun out
//     VRAM   : O_vid_addr, O_vid_wren, O_vid_data out; I_vid_data in
module video_vram_arbiter #(
  parameter int P_access_ticks = 2,
  parameter int P_starve_ticks = 8
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_tick,
  input  logic        I_rend_req,
  input  logic [13:0] I_rend_addr,
  output logic        O_rend_ack,
  output logic [7:0]  O_rend_data,
  input  logic        I_host_addr_wr,
  input  logic        I_host_data_wr,
  input  logic        I_host_data_rd,
  input  logic [7:0]  I_host_data,
  input  logic        I_toggle_clr,
  input  logic        I_incr32,
  output logic [7:0]  O_host_rdbuf,
  output logic        O_host_busy,
  output logic        O_overrun,
  output logic [13:0] O_vid_addr,
  output logic        O_vid_wren,
  input  logic [7:0]  I_vid_data,
  output logic [7:0]  O_vid_data
);

  typedef enum logic [1:0] {IDLE, REND, HWR, HRD} state_t;

  // Tick count (after the grant tick) at which a slot completes.
  localparam int         LAST_I   = (P_access_ticks > 1) ? P_access_ticks - 2 : 0;
  localparam logic [1:0] LAST_CNT = 2'(LAST_I);

  state_t      state;
  logic [1:0]  cnt;
  logic [13:0] v, v_next;
  logic        toggle, toggle_next;
  logic        pending, op_wr;
  logic [13:0] op_addr;
  logic [7:0]  op_data;

  logic strobe, accept, drop;
  logic host_active, slot_last, host_done, host_grant, host_force;

  assign strobe      = I_host_data_wr | I_host_data_rd;
  assign accept      = strobe & ~pending;
  // A strobe while busy is lost; a simultaneous wr+rd keeps the write and loses the read.
  assign drop        = (strobe & pending) | (I_host_data_wr & I_host_data_rd & ~pending);
  assign host_active = (state == HWR) || (state == HRD);
  assign slot_last   = (P_access_ticks == 1) ? 1'b1 : (I_tick && cnt == LAST_CNT);
  assign host_done   = host_active && slot_last;
  assign host_grant  = pending && (!I_rend_req || host_force);
  // pending stays set through the host slot, so it alone covers "busy".
  assign O_host_busy = pending;

`ifdef VIDEO_VRAM_STARVE_GUARD_EN
  localparam int            SW         = $clog2(P_starve_ticks + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(P_starve_ticks);
  logic [SW-1:0] starve_cnt;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && I_tick && host_grant) begin
      starve_cnt <= '0;
    end else if (I_tick && pending && !host_active && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign host_force = (starve_cnt == STARVE_MAX);
`else
  assign host_force = 1'b0;
`endif

  // Completion increment first, then a same-cycle PPUADDR write overrides
  // only the byte it targets.
  always_comb begin
    v_next      = host_done ? v + (I_incr32 ? 14'd32 : 14'd1) : v;
    toggle_next = toggle;
    if (I_host_addr_wr) begin
      if (!toggle) v_next[13:8] = I_host_data[5:0];
      else         v_next[7:0]  = I_host_data;
      toggle_next = ~toggle;
    end
    if (I_toggle_clr) toggle_next = 1'b0;
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      v            <= '0;
      toggle       <= 1'b0;
      pending      <= 1'b0;
      op_wr        <= 1'b0;
      op_addr      <= '0;
      op_data      <= '0;
      O_rend_ack   <= 1'b0;
      O_rend_data  <= '0;
      O_host_rdbuf <= '0;
      O_overrun    <= 1'b0;
      O_vid_addr   <= '0;
      O_vid_wren   <= 1'b0;
      O_vid_data   <= '0;
    end else begin
      O_rend_ack <= 1'b0;
      O_overrun  <= drop;
      v          <= v_next;
      toggle     <= toggle_next;

      // accept needs pending=0, host_done needs pending=1: never both.
      if (accept) begin
        pending <= 1'b1;
        op_wr   <= I_host_data_wr;
        op_addr <= v;
        op_data <= I_host_data;
      end else if (host_done) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (I_tick) begin
            cnt <= '0;
            if (host_grant) begin
              state      <= op_wr ? HWR : HRD;
              O_vid_addr <= op_addr;
              O_vid_wren <= op_wr;
              if (op_wr) O_vid_data <= op_data;
            end else if (I_rend_req) begin
              state      <= REND;
              O_vid_addr <= I_rend_addr;
            end
          end
        end
        default: begin
          if (slot_last) begin
            state      <= IDLE;
            O_vid_wren <= 1'b0;
            if (state == REND) begin
              O_rend_ack  <= 1'b1;
              O_rend_data <= I_vid_data;
            end else if (state == HRD) begin
              O_host_rdbuf <= I_vid_data;
            end
          end else if (I_tick) begin
            cnt <= cnt + 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_vram_arbiter.sv
// Self-checking bench for video_vram_arbiter: a transaction-level model
// (host op queue of depth one, slot tick counting, VRAM image) predicts
// every output each clock; directed scenarios add literal expectations.
module tb_video_vram_arbiter;
  localparam int ACC = 2;
  localparam int STV = 8;

  logic        I_clock = 1'b0, I_reset = 1'b0, I_tick = 1'b0;
  logic        I_rend_req = 1'b0;
  logic [13:0] I_rend_addr = '0;
  logic        I_host_addr_wr = 1'b0, I_host_data_wr = 1'b0, I_host_data_rd = 1'b0;
  logic [7:0]  I_host_data = '0;
  logic        I_toggle_clr = 1'b0, I_incr32 = 1'b0;
  logic [7:0]  I_vid_data;
  logic        O_rend_ack, O_host_busy, O_overrun, O_vid_wren;
  logic [7:0]  O_rend_data, O_host_rdbuf, O_vid_data;
  logic [13:0] O_vid_addr;

  video_vram_arbiter #(.P_access_ticks(ACC), .P_starve_ticks(STV)) dut (
    .I_clock(I_clock), .I_reset(I_reset), .I_tick(I_tick),
    .I_rend_req(I_rend_req), .I_rend_addr(I_rend_addr),
    .O_rend_ack(O_rend_ack), .O_rend_data(O_rend_data),
    .I_host_addr_wr(I_host_addr_wr), .I_host_data_wr(I_host_data_wr),
    .I_host_data_rd(I_host_data_rd), .I_host_data(I_host_data),
    .I_toggle_clr(I_toggle_clr), .I_incr32(I_incr32),
    .O_host_rdbuf(O_host_rdbuf), .O_host_busy(O_host_busy), .O_overrun(O_overrun),
    .O_vid_addr(O_vid_addr), .O_vid_wren(O_vid_wren),
    .I_vid_data(I_vid_data), .O_vid_data(O_vid_data)
  );

  always #5 I_clock = ~I_clock;

  // External VRAM seen by the DUT.
  bit [7:0] vram [16384];
  assign I_vid_data = vram[O_vid_addr];
  always @(posedge I_clock) if (O_vid_wren) vram[O_vid_addr] <= O_vid_data;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit [7:0]  mm [16384];           // model's image of VRAM
  bit [13:0] m_v;
  bit        m_tog, m_pend, m_pwr;
  bit [13:0] m_paddr;
  bit [7:0]  m_pdata;
  int        m_slot;               // 0 none, 1 render, 2 host write, 3 host read
  int        m_slot_ticks;         // ticks of the current slot, grant tick = 1
  int        m_wait;               // ticks a pending host op has waited
  bit [13:0] e_addr;
  bit        e_wren, e_ack, e_over;
  bit [7:0]  e_wdata, e_rdata, e_rdbuf;

  task automatic model_reset();
    m_v = 0; m_tog = 0; m_pend = 0; m_pwr = 0; m_paddr = 0; m_pdata = 0;
    m_slot = 0; m_slot_ticks = 0; m_wait = 0;
    e_addr = 0; e_wren = 0; e_ack = 0; e_over = 0; e_wdata = 0; e_rdata = 0; e_rdbuf = 0;
  endtask

  task automatic model_step();
    bit        old_pend = m_pend;
    int        old_slot = m_slot;
    bit        fin = 0, hsel, force_h;
    bit [13:0] nv = m_v;
    e_ack = 0;
    e_over = 0;
    if (old_slot != 0) begin
      if (ACC == 1) fin = 1;
      else if (I_tick) begin
        m_slot_ticks++;
        fin = (m_slot_ticks == ACC);
      end
    end
    if (fin) begin
      if (old_slot == 1) begin e_ack = 1; e_rdata = mm[e_addr]; end
      if (old_slot == 3) e_rdbuf = mm[e_addr];
      if (old_slot >= 2) begin nv = m_v + (I_incr32 ? 14'd32 : 14'd1); m_pend = 0; end
      m_slot = 0;
      e_wren = 0;
    end
`ifdef VIDEO_VRAM_STARVE_GUARD_EN
    force_h = (m_wait >= STV);
`else
    force_h = 0;
`endif
    hsel = 0;
    if (old_slot == 0 && I_tick) begin
      hsel = old_pend && (!I_rend_req || force_h);
      if (hsel) begin
        m_slot = m_pwr ? 2 : 3;
        e_addr = m_paddr;
        e_wren = m_pwr;
        if (m_pwr) begin e_wdata = m_pdata; mm[m_paddr] = m_pdata; end
        m_slot_ticks = 1;
      end else if (I_rend_req) begin
        m_slot = 1;
        e_addr = I_rend_addr;
        m_slot_ticks = 1;
      end
    end
    if (hsel) m_wait = 0;
    else if (I_tick && old_pend && old_slot < 2 && m_wait < STV) m_wait++;
    if (I_host_data_wr || I_host_data_rd) begin
      if (old_pend || (I_host_data_wr && I_host_data_rd)) e_over = 1;
      if (!old_pend) begin
        m_pend = 1; m_pwr = I_host_data_wr; m_paddr = m_v; m_pdata = I_host_data;
      end
    end
    if (I_host_addr_wr) begin
      if (!m_tog) nv[13:8] = I_host_data[5:0];
      else        nv[7:0]  = I_host_data;
      m_tog = !m_tog;
    end
    if (I_toggle_clr) m_tog = 0;
    m_v = nv;
  endtask

  // ---------------- cycle driver + compare ----------------
  int tick_gap = 2, tick_cd = 0, tick_no = 0;
  bit rand_gap = 0;
  bit wr_seen; int wr_tick; int wr_addr;
  int ov_cnt;
  bit ack_mon = 0; int ack_cnt; int last_ack_tick;

  task automatic compare();
    chk("vid_addr", O_vid_addr, e_addr);
    chk("vid_wren", O_vid_wren, e_wren);
    chk("vid_data", O_vid_data, e_wdata);
    chk("rend_ack", O_rend_ack, e_ack);
    chk("rend_data", O_rend_data, e_rdata);
    chk("host_rdbuf", O_host_rdbuf, e_rdbuf);
    chk("host_busy", O_host_busy, m_pend);
    chk("overrun", O_overrun, e_over);
    if (O_vid_wren && !wr_seen) begin wr_seen = 1; wr_tick = tick_no; wr_addr = O_vid_addr; end
    if (O_overrun) ov_cnt++;
    if (ack_mon && O_rend_ack) begin
      chk("starve_rend_data", O_rend_data, 8'hAB);
`ifndef VIDEO_VRAM_STARVE_GUARD_EN
      if (ack_cnt > 0) chk("starve_ack_period", tick_no - last_ack_tick, 2);
`endif
      ack_cnt++;
      last_ack_tick = tick_no;
    end
  endtask

  task automatic cycle();
    if (tick_cd == 0) begin
      I_tick = 1; tick_no++;
      tick_cd = rand_gap ? $urandom_range(1, 4) : tick_gap;
    end else begin
      I_tick = 0; tick_cd--;
    end
    model_step();
    @(posedge I_clock); #1;
    compare();
    I_host_addr_wr = 0; I_host_data_wr = 0; I_host_data_rd = 0; I_toggle_clr = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic addr_wr(input logic [7:0] d);
    I_host_addr_wr = 1; I_host_data = d; cycle();
  endtask
  task automatic data_wr(input logic [7:0] d);
    I_host_data_wr = 1; I_host_data = d; cycle();
  endtask
  task automatic data_rd();
    I_host_data_rd = 1; cycle();
  endtask
  task automatic wait_host(input string nm);
    for (int i = 0; i < 200 && (m_pend || m_slot != 0); i++) cycle();
    chk(nm, m_pend, 0);
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_vid_addr"}, O_vid_addr, 0);
    chk({nm, "_vid_wren"}, O_vid_wren, 0);
    chk({nm, "_vid_data"}, O_vid_data, 0);
    chk({nm, "_rend_ack"}, O_rend_ack, 0);
    chk({nm, "_rend_data"}, O_rend_data, 0);
    chk({nm, "_rdbuf"}, O_host_rdbuf, 0);
    chk({nm, "_busy"}, O_host_busy, 0);
    chk({nm, "_overrun"}, O_overrun, 0);
  endtask

  int t0;

  initial begin
    model_reset();
    repeat (3) @(posedge I_clock);
    #1;
    check_zero_outputs("reset");
    I_reset = 1;

    run(4);

    // Write 0x5A through PPUADDR 0x2108.
    addr_wr(8'h21); addr_wr(8'h08);
    t0 = tick_no; wr_seen = 0;
    data_wr(8'h5A);
    wait_host("t1_done");
    chk("t1_addr", wr_addr, 14'h2108);
    chk("t1_latency_le2", int'(wr_seen && (wr_tick - t0) <= 2), 1);
    chk("t1_vram", vram[14'h2108], 8'h5A);
    chk("t1_model_v", m_v, 14'h2109);

    // +32 wrap at the top of the address space.
    I_incr32 = 1;
    addr_wr(8'h3F); addr_wr(8'hF0);
    data_wr(8'h11);
    wait_host("t2_done");
    chk("t2_model_v", m_v, 14'h0010);
    wr_seen = 0;
    data_wr(8'h22);
    wait_host("t2b_done");
    chk("t2_wrap_addr", wr_addr, 14'h0010);
    I_incr32 = 0;

    // Buffered PPUDATA reads.
    addr_wr(8'h20); addr_wr(8'h00); data_wr(8'h77); wait_host("t3_wr");
    addr_wr(8'h20); addr_wr(8'h00);
    data_rd();
    chk("t3_stale_rdbuf", O_host_rdbuf, 8'h00);
    wait_host("t3_rd1");
    chk("t3_rdbuf", O_host_rdbuf, 8'h77);
    run(6);
    data_rd();
    wait_host("t3_rd2");
    chk("t3_model_v", m_v, 14'h2002);

    // Back-to-back PPUDATA writes: second is dropped.
    addr_wr(8'h05); addr_wr(8'h00);
    ov_cnt = 0;
    data_wr(8'hC1); data_wr(8'hC2);
    wait_host("t4_done");
    run(3);
    chk("t4_overrun_pulses", ov_cnt, 1);
    chk("t4_vram_first", vram[14'h0500], 8'hC1);
    chk("t4_vram_second", vram[14'h0501], 8'h00);

    // Render held continuously against a pending host write.
    addr_wr(8'h01); addr_wr(8'h23); data_wr(8'hAB); wait_host("t5_prep");
    addr_wr(8'h04); addr_wr(8'h00);
    I_rend_req = 1; I_rend_addr = 14'h0123;
    for (int i = 0; i < 20 && m_slot != 1; i++) cycle();
    ack_cnt = 0; ack_mon = 1; wr_seen = 0;
    data_wr(8'h99);
    t0 = tick_no;
    run(60);
    ack_mon = 0;
`ifdef VIDEO_VRAM_STARVE_GUARD_EN
    chk("starve_host_served", wr_seen, 1);
    chk("starve_bound_le10", int'(wr_seen && (wr_tick - t0) <= 10), 1);
`else
    chk("starve_host_never", wr_seen, 0);
    chk("starve_busy", O_host_busy, 1);
    chk("starve_ack_count_ge9", int'(ack_cnt >= 9), 1);
`endif
    I_rend_req = 0;
    wait_host("t5_release");
    chk("t5_vram", vram[14'h0400], 8'h99);

    // Randomized traffic.
    rand_gap = 1;
    for (int c = 0; c < 3000; c++) begin
      int r = $urandom_range(0, 15);
      if (I_rend_req) begin
        if (e_ack) begin
          if ($urandom_range(0, 1) == 1) I_rend_req = 0;
          else I_rend_addr = {6'h20, 8'($urandom_range(0, 63))};
        end
      end else if ($urandom_range(0, 3) == 0) begin
        I_rend_req = 1;
        I_rend_addr = {6'h20, 8'($urandom_range(0, 63))};
      end
      I_host_data = $urandom_range(0, 1) == 1 ? 8'h20 : 8'($urandom_range(0, 63));
      case (r)
        0: I_host_addr_wr = 1;
        1: I_host_data_wr = 1;
        2: I_host_data_rd = 1;
        3: I_toggle_clr = 1;
        4: I_incr32 = ~I_incr32;
        5: begin I_host_addr_wr = 1; I_toggle_clr = 1; end
        default: ;
      endcase
      cycle();
    end
    rand_gap = 0;
    I_rend_req = 0; I_incr32 = 0;
    wait_host("rand_drain");

    // Reset in the middle of a host write slot.
    I_toggle_clr = 1; cycle();
    addr_wr(8'h06); addr_wr(8'h66);
    data_wr(8'h5C);
    for (int i = 0; i < 20 && !O_vid_wren; i++) cycle();
    chk("rst_in_hwr", O_vid_wren, 1);
    I_reset = 0;
    #1;
    check_zero_outputs("midslot_reset");
    model_reset();
    @(posedge I_clock); #1;
    I_reset = 1;
    tick_cd = 0;
    run(3);
    data_wr(8'h3C);
    wait_host("rst_post_wr");
    chk("rst_v_zero", vram[14'h0000], 8'h3C);
    chk("rst_model_v", m_v, 14'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
